// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX-side arbiter and its helpers.
// Holds the TX arbiter state encoding, parity mode selectors, the default
// start-handshake timeout, the timeout counter width, and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } tx_state_e;

  localparam int unsigned PARITY_EVEN           = 0;
  localparam int unsigned PARITY_ODD            = 1;
  localparam int unsigned START_TIMEOUT_DEFAULT = 16;
  localparam int unsigned CNT_W                 = 8;

  // XOR reduction of the byte, inverted for odd parity.
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// rr_arbiter2: two-way round-robin arbiter with its owner register.
// Ports:
//   clk, reset      - system clock, asynchronous active-low reset
//   en              - grants are only issued while en is high
//   req_a, req_b    - request levels
//   grant_a/grant_b - combinational one-hot grant (zero when en is low)
//   owner           - last granted requester (0 = A, 1 = B); 0 out of reset
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b,
  output logic owner
);

  logic r_owner;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        // On contention the requester that did not win last time goes next.
        grant_a = r_owner;
        grant_b = ~r_owner;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= 1'b0;
    end else if (grant_a) begin
      r_owner <= 1'b0;
    end else if (grant_b) begin
      r_owner <= 1'b1;
    end
  end

  assign owner = r_owner;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter core between two byte
// requesters (A, B) with round-robin arbitration.
// Ports:
//   clk, reset           - system clock, asynchronous active-low reset
//   req_a/data_a         - requester A level request and byte
//   req_b/data_b         - requester B level request and byte
//   ack_a, ack_b         - one-cycle pulse: that requester's byte was latched
//   tx_start             - one-cycle start pulse to the transmitter core
//   tx_data, tx_paridad  - latched byte and its parity bit
//   tx_busy              - transmitter frame in progress (already synchronised)
//   owner                - last granted requester (0 = A, 1 = B)
//   busy                 - high whenever not IDLE
//   err_timeout          - one-cycle pulse when tx_busy never rose after tx_start
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned ODD_PARITY    = PARITY_EVEN,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       tx_paridad,
  input  logic       tx_busy,
  output logic       owner,
  output logic       busy,
  output logic       err_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic             PAR_INV  = (ODD_PARITY != 0);

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_tx_data;
  logic             r_tx_par;
  logic             r_ack_a;
  logic             r_ack_b;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_arb_en;
  logic             w_owner;
  logic             w_err;

  assign w_arb_en = (r_state == IDLE);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (w_arb_en),
    .req_a   (req_a),
    .req_b   (req_b),
    .grant_a (w_grant_a),
    .grant_b (w_grant_b),
    .owner   (w_owner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_a || w_grant_b) w_state_nxt = GRANT;
      end
      GRANT: begin
        w_state_nxt = START;
      end
      START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt == CNT_LAST) begin
          // Byte is dropped; no retry.
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_tx_par  <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack_a <= w_grant_a;
      r_ack_b <= w_grant_b;
      if (w_grant_a) begin
        r_tx_data <= data_a;
        r_tx_par  <= parity_bit(data_a, PAR_INV);
      end else if (w_grant_b) begin
        r_tx_data <= data_b;
        r_tx_par  <= parity_bit(data_b, PAR_INV);
      end
    end
  end

  assign ack_a       = r_ack_a;
  assign ack_b       = r_ack_b;
  assign tx_start    = (r_state == START);
  assign tx_data     = r_tx_data;
  assign tx_paridad  = r_tx_par;
  assign owner       = w_owner;
  assign busy        = (r_state != IDLE);
  assign err_timeout = w_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: dut0 uses even parity and the default timeout
// with a transmitter model; dut1 uses odd parity, START_TIMEOUT = 4 and a
// transmitter that never answers.
module tb_uart_tx_arbiter;

  localparam int W_ACK0   = 0;
  localparam int W_START0 = 1;
  localparam int W_IDLE0  = 2;
  localparam int W_ACK1   = 3;
  localparam int W_START1 = 4;
  localparam int W_IDLE1  = 5;
  localparam int W_TXHI0  = 6;
  localparam int W_TXLO0  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_a0, req_b0, req_a1, req_b1;
  logic [7:0] data_a0, data_b0, data_a1, data_b1;
  logic       tx_busy0;
  logic       tx_busy1;
  logic       ack_a0, ack_b0, tx_start0, tx_par0, owner0, busy0, err0;
  logic       ack_a1, ack_b1, tx_start1, tx_par1, owner1, busy1, err1;
  logic [7:0] tx_data0, tx_data1;

  assign tx_busy1 = 1'b0;

  uart_tx_arbiter #(.ODD_PARITY(0), .START_TIMEOUT(16)) dut0 (
    .clk(clk), .reset(rst_n),
    .req_a(req_a0), .data_a(data_a0), .req_b(req_b0), .data_b(data_b0),
    .ack_a(ack_a0), .ack_b(ack_b0), .tx_start(tx_start0), .tx_data(tx_data0),
    .tx_paridad(tx_par0), .tx_busy(tx_busy0), .owner(owner0), .busy(busy0),
    .err_timeout(err0)
  );

  uart_tx_arbiter #(.ODD_PARITY(1), .START_TIMEOUT(4)) dut1 (
    .clk(clk), .reset(rst_n),
    .req_a(req_a1), .data_a(data_a1), .req_b(req_b1), .data_b(data_b1),
    .ack_a(ack_a1), .ack_b(ack_b1), .tx_start(tx_start1), .tx_data(tx_data1),
    .tx_paridad(tx_par1), .tx_busy(tx_busy1), .owner(owner1), .busy(busy1),
    .err_timeout(err1)
  );

  int checks = 0;
  int errors = 0;
  int ack_a_cnt0 = 0, ack_b_cnt0 = 0, start_cnt1 = 0, err_cnt1 = 0;
  logic [9:0] exp0[$];  // {owner, parity, data}
  logic [8:0] exp1[$];  // {parity, data}

  always @(negedge clk) begin
    if (ack_a0)    ack_a_cnt0 <= ack_a_cnt0 + 1;
    if (ack_b0)    ack_b_cnt0 <= ack_b_cnt0 + 1;
    if (tx_start1) start_cnt1 <= start_cnt1 + 1;
    if (err1)      err_cnt1   <= err_cnt1 + 1;
  end

  // Transmitter model: tx_busy high from 3 cycles after tx_start, for 20 cycles.
  int m_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      tx_busy0 <= 1'b0;
    end else if (tx_start0) begin
      m_cnt <= 1;
    end else if (m_cnt != 0) begin
      tx_busy0 <= (m_cnt >= 2 && m_cnt < 22);
      m_cnt    <= (m_cnt == 22) ? 0 : m_cnt + 1;
    end
  end

  task automatic wait_for(input int sel, input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      case (sel)
        W_ACK0:   if (ack_a0 || ack_b0) to = 1'b0;
        W_START0: if (tx_start0)        to = 1'b0;
        W_IDLE0:  if (!busy0)           to = 1'b0;
        W_ACK1:   if (ack_a1 || ack_b1) to = 1'b0;
        W_START1: if (tx_start1)        to = 1'b0;
        W_IDLE1:  if (!busy1)           to = 1'b0;
        W_TXHI0:  if (tx_busy0)         to = 1'b0;
        W_TXLO0:  if (!tx_busy0)        to = 1'b0;
        default:  to = 1'b1;
      endcase
      if (!to) break;
    end
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst_n = 1'b0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    data_a0 = 8'h11; data_b0 = 8'h22; data_a1 = 8'h33; data_b1 = 8'h44;
    repeat (3) @(negedge clk);
    got = {ack_a0, ack_b0, tx_start0, tx_data0, tx_par0, owner0, busy0, err0};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_dut0 got %h expected 0", got); end
    got = {ack_a1, ack_b1, tx_start1, tx_data1, tx_par1, owner1, busy1, err1};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_dut1 got %h expected 0", got); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, ack_a0, ack_b0} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b expected 000", {busy0, ack_a0, ack_b0});
    end
  endtask

  task automatic test_single();
    bit to;
    int a_before;
    logic [9:0] e;
    @(negedge clk);
    data_a0 = 8'hA5; req_a0 = 1'b1;
    exp0.push_back({1'b0, 1'b0, 8'hA5});
    #1 a_before = ack_a_cnt0;
    wait_for(W_ACK0, 10, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL single_ack got timeout expected ack"); end
    checks++;
    if ({ack_a0, ack_b0} !== 2'b10) begin
      errors++; $display("FAIL single_ack_who got %b expected 10", {ack_a0, ack_b0});
    end
    req_a0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_start0, ack_a0} !== 2'b10) begin
      errors++; $display("FAIL single_latency got start,ack=%b expected 10", {tx_start0, ack_a0});
    end
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    checks++;
    if ({owner0, tx_par0, tx_data0} !== e) begin
      errors++; $display("FAIL single_frame got %h expected %h", {owner0, tx_par0, tx_data0}, e);
    end
    wait_for(W_TXHI0, 10, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL single_txbusy_rise got timeout expected rise"); end
    wait_for(W_TXLO0, 30, to);
    checks++;
    if (busy0 !== 1'b1 || to !== 1'b0) begin
      errors++; $display("FAIL single_busy_hold got busy=%b to=%b expected 1 0", busy0, to);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b expected 0", busy0); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ack_a_cnt0 - a_before !== 1) begin
      errors++; $display("FAIL single_ack_count got %0d expected 1", ack_a_cnt0 - a_before);
    end
  endtask

  task automatic test_contention();
    bit to;
    logic [9:0] e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    data_a0 = 8'h01; data_b0 = 8'h02; req_a0 = 1'b1; req_b0 = 1'b1;
    exp0.push_back({1'b1, 1'b1, 8'h02});
    exp0.push_back({1'b0, 1'b1, 8'h01});
    for (int k = 0; k < 2; k++) begin
      wait_for(W_ACK0, 10, to);
      checks++;
      if (to !== 1'b0 || ack_b0 !== (k == 0)) begin
        errors++; $display("FAIL contention_grant%0d got ack_b=%b to=%b expected %b 0", k, ack_b0, to, k == 0);
      end
      if (ack_b0) req_b0 = 1'b0;
      if (ack_a0) req_a0 = 1'b0;
      wait_for(W_START0, 5, to);
      e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
      checks++;
      if (to !== 1'b0 || {owner0, tx_par0, tx_data0} !== e) begin
        errors++; $display("FAIL contention_frame%0d got %h expected %h", k, {owner0, tx_par0, tx_data0}, e);
      end
      wait_for(W_IDLE0, 60, to);
    end
    req_a0 = 1'b0; req_b0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit to;
    int a_before, b_before;
    logic [9:0] e;
    @(negedge clk);
    #1 a_before = ack_a_cnt0; b_before = ack_b_cnt0;
    data_a0 = 8'h3C; data_b0 = 8'h07; req_a0 = 1'b1; req_b0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp0.push_back({1'b1, 1'b1, 8'h07});
      else            exp0.push_back({1'b0, 1'b0, 8'h3C});
    end
    for (int k = 0; k < 4; k++) begin
      wait_for(W_ACK0, 10, to);
      checks++;
      if (to !== 1'b0 || ack_b0 !== (k % 2 == 0)) begin
        errors++; $display("FAIL sustained_grant%0d got ack_b=%b to=%b expected %b 0", k, ack_b0, to, k % 2 == 0);
      end
      if (k == 3) begin req_a0 = 1'b0; req_b0 = 1'b0; end
      wait_for(W_START0, 5, to);
      e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
      checks++;
      if (to !== 1'b0 || {owner0, tx_par0, tx_data0} !== e) begin
        errors++; $display("FAIL sustained_frame%0d got %h expected %h", k, {owner0, tx_par0, tx_data0}, e);
      end
      wait_for(W_IDLE0, 60, to);
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (ack_a_cnt0 - a_before !== 2 || ack_b_cnt0 - b_before !== 2) begin
      errors++; $display("FAIL sustained_acks got a=%0d b=%0d expected 2 2",
                         ack_a_cnt0 - a_before, ack_b_cnt0 - b_before);
    end
  endtask

  task automatic test_odd_parity();
    bit to;
    logic [8:0] e;
    @(negedge clk);
    data_a1 = 8'hFF; req_a1 = 1'b1;
    exp1.push_back({1'b1, 8'hFF});
    wait_for(W_ACK1, 10, to);
    req_a1 = 1'b0;
    wait_for(W_START1, 5, to);
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    checks++;
    if (to !== 1'b0 || {tx_par1, tx_data1} !== e) begin
      errors++; $display("FAIL odd_parity_ff got %h expected %h", {tx_par1, tx_data1}, e);
    end
    wait_for(W_IDLE1, 20, to);
  endtask

  task automatic test_timeout();
    bit to;
    int s_before, e_before, n;
    logic [8:0] e;
    @(negedge clk);
    #1 s_before = start_cnt1; e_before = err_cnt1;
    data_a1 = 8'h80; req_a1 = 1'b1;
    exp1.push_back({1'b0, 8'h80});
    wait_for(W_ACK1, 10, to);
    req_a1 = 1'b0;
    wait_for(W_START1, 5, to);
    e = (exp1.size() != 0) ? exp1.pop_front() : 'x;
    checks++;
    if (to !== 1'b0 || {tx_par1, tx_data1} !== e) begin
      errors++; $display("FAIL odd_parity_80 got %h expected %h", {tx_par1, tx_data1}, e);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (err1) break;
    end
    checks++;
    if (n !== 4 || err1 !== 1'b1) begin
      errors++; $display("FAIL timeout_delay got %0d cycles err=%b expected 4 1", n, err1);
    end
    @(negedge clk);
    checks++;
    if ({busy1, err1} !== 2'b00) begin
      errors++; $display("FAIL timeout_idle got busy,err=%b expected 00", {busy1, err1});
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (start_cnt1 - s_before !== 1 || err_cnt1 - e_before !== 1) begin
      errors++; $display("FAIL timeout_no_retry got starts=%0d errs=%0d expected 1 1",
                         start_cnt1 - s_before, err_cnt1 - e_before);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [14:0] got;
    logic [9:0] e;
    @(negedge clk);
    data_b0 = 8'h5A; req_b0 = 1'b1;
    wait_for(W_ACK0, 10, to);
    req_b0 = 1'b0;
    wait_for(W_TXHI0, 10, to);
    @(negedge clk);
    checks++;
    if ({busy0, owner0, to} !== 3'b110) begin
      errors++; $display("FAIL mid_wait_done got busy,owner,to=%b expected 110", {busy0, owner0, to});
    end
    #2 rst_n = 1'b0;
    #1;
    got = {ack_a0, ack_b0, tx_start0, tx_data0, tx_par0, owner0, busy0, err0};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL mid_async_reset got %h expected 0", got); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    data_b0 = 8'h81; req_b0 = 1'b1;
    exp0.push_back({1'b1, 1'b0, 8'h81});
    wait_for(W_ACK0, 10, to);
    checks++;
    if (to !== 1'b0 || {ack_a0, ack_b0} !== 2'b01) begin
      errors++; $display("FAIL mid_regrant got ack=%b to=%b expected 01 0", {ack_a0, ack_b0}, to);
    end
    req_b0 = 1'b0;
    wait_for(W_START0, 5, to);
    e = (exp0.size() != 0) ? exp0.pop_front() : 'x;
    checks++;
    if (to !== 1'b0 || {owner0, tx_par0, tx_data0} !== e) begin
      errors++; $display("FAIL mid_frame got %h expected %h", {owner0, tx_par0, tx_data0}, e);
    end
    wait_for(W_IDLE0, 60, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL mid_done got timeout expected idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_odd_parity();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter core between two byte requesters (A, B), using round-robin arbitration. It latches the granted byte and generates its parity bit. It issues a one-cycle start pulse to the transmitter and tracks the transmitter's busy flag until the frame completes. It sits between the system-side producers and the divided-clock TX datapath, mirroring the RX side of the full-duplex UART.

Parameters:
ODD_PARITY, 0, 0 = even parity on tx_paridad, 1 = odd parity.
START_TIMEOUT, 16, max clk cycles to wait for tx_busy to rise after tx_start; range 2..255.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
req_a  input  1  requester A has a byte pending; held until ack_a.
data_a  input  8  requester A byte; stable while req_a high.
req_b  input  1  requester B has a byte pending; held until ack_b.
data_b  input  8  requester B byte; stable while req_b high.
ack_a  output  1  one-cycle pulse: A's byte latched.
ack_b  output  1  one-cycle pulse: B's byte latched.
tx_start  output  1  one-cycle pulse to the transmitter core.
tx_data  output  8  latched byte; held stable from tx_start until return to IDLE.
tx_paridad  output  1  parity of tx_data per ODD_PARITY; registered together with tx_data.
tx_busy  input  1  transmitter frame in progress (synchronised externally into the clk domain).
owner  output  1  0 = A, 1 = B; the last granted requester.
busy  output  1  high in every state except IDLE.
err_timeout  output  1  one-cycle pulse when tx_busy fails to rise within START_TIMEOUT.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE. All outputs are 0, including owner = 0, so B has priority on the first contention. Timeout counter = 0.
- States: IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE.
- IDLE, with only one req high: grant that requester.
- IDLE, with both req high: grant the requester that is not owner (round-robin). Otherwise stay in IDLE.
- On a grant:
  - latch the data into tx_data and compute tx_paridad (XOR reduction, inverted if ODD_PARITY = 1);
  - update owner;
  - pulse ack_x in the same cycle;
  - go to GRANT.
- GRANT: one settling cycle, then go to START. tx_data is stable for at least one clk cycle before tx_start.
- START: tx_start = 1 for exactly this cycle. Clear the counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy = 1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When counter = START_TIMEOUT - 1 and tx_busy is still 0: pulse err_timeout, go to IDLE, and drop the byte. No retry.
- WAIT_DONE: when tx_busy = 0, go to IDLE. There is no timeout, because frame length depends on the baud rate.
- Latency: the earliest tx_start comes 2 cycles after req is sampled high in IDLE (grant edge, then GRANT, then START).
- Back-to-back: the next grant can occur in the cycle after WAIT_DONE returns to IDLE.
- A requester that drops req before ack is simply not granted. A req dropped after grant does not affect the current transfer.
- A req that rises while the block is not in IDLE waits; it is not queued beyond its own held level.
- tx_busy already high in START (core still busy): the block proceeds to WAIT_BUSY and accepts it immediately. Producers must not overlap with other users of the core.
- Reset asserted mid-transfer: immediate return to IDLE with outputs cleared. The byte in flight is lost, and the transmitter core is reset by the same net.
- Counter width: 8 bits.

Decomposition:
- Shared package (uart_pkg): state encoding constants (IDLE = 0 … WAIT_DONE = 4, 3 bits), parity mode constants, and the default START_TIMEOUT.
- One natural sub-module: rr_arbiter2. It is combinational plus the owner register; inputs req_a, req_b and owner; outputs grant_a and grant_b. It is reused by the planned RX-buffer read arbiter.

Test Plan:
- Single request: req_a = 1, data_a = 8'hA5 (even parity), transmitter model raises tx_busy 3 cycles after tx_start and holds it 20 cycles. Required response:
  - ack_a pulses once;
  - tx_start comes 2 cycles after the grant;
  - tx_data = A5 and tx_paridad = 0;
  - busy falls 1 cycle after tx_busy falls.
- Contention from reset: req_a and req_b high together with data_a = 8'h01 and data_b = 8'h02. Required response:
  - the first grant is B (tx_data = 02, tx_paridad = 1), then A (tx_data = 01);
  - owner sequence is 1 then 0.
- Sustained contention: both req held high for 4 transfers. Required response: grants alternate B, A, B, A; no starvation; exactly 4 ack pulses.
- Odd parity: ODD_PARITY = 1, data = 8'hFF. Required response: tx_paridad = 1 for data FF, and tx_paridad = 0 for data 8'h80.
- Timeout: START_TIMEOUT = 4, tx_busy held at 0. Required response:
  - err_timeout pulses once, 4 cycles after tx_start;
  - state returns to IDLE;
  - no second tx_start for that byte.
- Reset mid-transfer: assert reset = 0 during WAIT_DONE. Required response:
  - all outputs are 0 within the same cycle (asynchronous);
  - after release with req_b = 1, a normal grant to B follows.
